// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache memory-side controller.
// Holds state encodings, default widths and the line-alignment function.
package cache_pkg;

  localparam int ADDR_W         = 32;
  localparam int OFS_BITS       = 6;
  localparam int LINE_SIZE_BITS = 32;
  localparam int WB_DEPTH_DEF   = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_RESP = 2'd2;
  localparam state_t ST_WR   = 2'd3;

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [ADDR_W-1:0] a
  );
    logic [ADDR_W-1:0] m;
    m = '1;
    m[OFS_BITS-1:0] = '0;
    return a & m;
  endfunction

endpackage

// File: rtl/cache_mem_ctrl_wb_buffer.sv
// Write-back buffer: FIFO of evicted lines with a youngest-match lookup.
// Ports: push/pop handshake, head entry, full/empty/overflow, lookup hit+data.
module wb_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic [AW-1:0] lookup_addr,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_q;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign do_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign overflow  = ovf_q;

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) &&
          (addr_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side stage below the cache: line fills, write-back drain, forwarding.
// Ports: cache miss/evict in, fill response out, single req/ack memory bus.
module cache_mem_ctrl #(
  parameter int ADDRESS_WIDTH  = cache_pkg::ADDR_W,
  parameter int LINE_SIZE_BITS = cache_pkg::LINE_SIZE_BITS,
  parameter int OFFSET_BITS    = cache_pkg::OFS_BITS,
  parameter int WB_DEPTH       = cache_pkg::WB_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_miss,
  input  logic [ADDRESS_WIDTH-1:0]  i_miss_addr,
  input  logic                      i_evict,
  input  logic [ADDRESS_WIDTH-1:0]  i_evict_addr,
  input  logic [LINE_SIZE_BITS-1:0] i_evict_data,
  output logic [LINE_SIZE_BITS-1:0] o_memory_line,
  output logic                      o_memory_response,
  output logic                      o_wb_full,
  output logic                      o_wb_overflow,
  output logic                      o_mem_req,
  output logic                      o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]  o_mem_addr,
  output logic [LINE_SIZE_BITS-1:0] o_mem_wdata,
  input  logic                      i_mem_ack,
  input  logic [LINE_SIZE_BITS-1:0] i_mem_rdata
);

  import cache_pkg::*;

  state_t                    state_q;
  state_t                    state_nx;
  logic                      req_q;
  logic                      we_q;
  logic [ADDRESS_WIDTH-1:0]  addr_q;
  logic [LINE_SIZE_BITS-1:0] wdata_q;
  logic [LINE_SIZE_BITS-1:0] fill_q;

  logic [ADDRESS_WIDTH-1:0]  miss_line;
  logic [ADDRESS_WIDTH-1:0]  evict_line;
  logic                      wb_pop;
  logic                      wb_empty;
  logic                      wb_hit;
  logic [LINE_SIZE_BITS-1:0] wb_hit_data;
  logic [ADDRESS_WIDTH-1:0]  wb_head_addr;
  logic [LINE_SIZE_BITS-1:0] wb_head_data;

  logic start_rd;
  logic start_wr;
  logic in_bus;

  assign miss_line  = line_addr(i_miss_addr);
  assign evict_line = line_addr(i_evict_addr);
  assign wb_pop     = (state_q == ST_WR) && i_mem_ack;

  wb_buffer #(
    .DEPTH (WB_DEPTH),
    .AW    (ADDRESS_WIDTH),
    .DW    (LINE_SIZE_BITS)
  ) u_wb (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (i_evict),
    .push_addr   (evict_line),
    .push_data   (i_evict_data),
    .pop         (wb_pop),
    .lookup_addr (miss_line),
    .head_addr   (wb_head_addr),
    .head_data   (wb_head_data),
    .empty       (wb_empty),
    .full        (o_wb_full),
    .overflow    (o_wb_overflow),
    .hit         (wb_hit),
    .hit_data    (wb_hit_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_nx;
  end

  // Fill beats drain; an in-flight write is always finished first.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_miss)
          state_nx = wb_hit ? ST_RESP : ST_RD;
        else if (!wb_empty)
          state_nx = ST_WR;
      end
      ST_RD:   if (i_mem_ack) state_nx = ST_RESP;
      ST_WR:   if (i_mem_ack) state_nx = ST_IDLE;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign start_rd = (state_q == ST_IDLE) &&
                    (state_nx == ST_RD);
  assign start_wr = (state_q == ST_IDLE) &&
                    (state_nx == ST_WR);
  assign in_bus   = (state_nx == ST_RD) ||
                    (state_nx == ST_WR);

  // Bus fields load on entry and hold through the ack cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      req_q <= in_bus;
      if (start_rd) begin
        we_q    <= 1'b0;
        addr_q  <= miss_line;
        wdata_q <= '0;
      end else if (start_wr) begin
        we_q    <= 1'b1;
        addr_q  <= wb_head_addr;
        wdata_q <= wb_head_data;
      end else if (!in_bus) begin
        we_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fill_q <= '0;
    else if ((state_q == ST_IDLE) && i_miss && wb_hit)
      fill_q <= wb_hit_data;
    else if ((state_q == ST_RD) && i_mem_ack)
      fill_q <= i_mem_rdata;
  end

  always_comb begin
    o_memory_response = (state_q == ST_RESP);
    o_memory_line     = fill_q;
    o_mem_req         = req_q;
    o_mem_we          = we_q;
    o_mem_addr        = addr_q;
    o_mem_wdata       = wdata_q;
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: fills, forwarding, drain order, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cache_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss;
  logic [31:0] i_miss_addr;
  logic        i_evict;
  logic [31:0] i_evict_addr;
  logic [31:0] i_evict_data;
  logic [31:0] o_memory_line;
  logic        o_memory_response;
  logic        o_wb_full;
  logic        o_wb_overflow;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_mem_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_miss            (i_miss),
    .i_miss_addr       (i_miss_addr),
    .i_evict           (i_evict),
    .i_evict_addr      (i_evict_addr),
    .i_evict_data      (i_evict_data),
    .o_memory_line     (o_memory_line),
    .o_memory_response (o_memory_response),
    .o_wb_full         (o_wb_full),
    .o_wb_overflow     (o_wb_overflow),
    .o_mem_req         (o_mem_req),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .i_mem_ack         (i_mem_ack),
    .i_mem_rdata       (i_mem_rdata)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic evict(input logic [31:0] a,
                       input logic [31:0] d);
    i_evict      = 1'b1;
    i_evict_addr = a;
    i_evict_data = d;
  endtask

  // Wait for a request, check it, hold for dly cycles, then ack.
  task automatic do_ack(input string tag,
                        input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input int dly,
                        input logic [31:0] rdata);
    int k;
    k = 0;
    while (!o_mem_req && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_req"}, o_mem_req, 1'b1);
    if (!o_mem_req) return;
    check({tag, "_we"}, o_mem_we, we);
    check({tag, "_addr"}, o_mem_addr, addr);
    if (we)
      check({tag, "_wdata"}, o_mem_wdata, wdata);
    for (int i = 0; i < dly; i++) begin
      tick();
      check({tag, "_hold"}, {o_mem_req, o_mem_addr},
            {1'b1, addr});
      check({tag, "_noresp"}, o_memory_response, 1'b0);
    end
    i_mem_ack   = 1'b1;
    i_mem_rdata = rdata;
    tick();
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    check({tag, "_drop"}, o_mem_req, 1'b0);
  endtask

  // Wait for the fill pulse, check data, drop miss, check pulse width.
  task automatic wait_resp(input string tag,
                           input logic [31:0] line,
                           input int max);
    int k;
    k = 0;
    while (!o_memory_response && k < max) begin
      tick();
      k++;
    end
    check({tag, "_resp"}, o_memory_response, 1'b1);
    check({tag, "_line"}, o_memory_line, line);
    i_miss = 1'b0;
    tick();
    check({tag, "_pulse"}, o_memory_response, 1'b0);
    check({tag, "_held"}, o_memory_line, line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    i_miss       = 1'b0;
    i_miss_addr  = '0;
    i_evict      = 1'b0;
    i_evict_addr = '0;
    i_evict_data = '0;
    i_mem_ack    = 1'b0;
    i_mem_rdata  = '0;
    repeat (2) tick();
    check("rst_resp", o_memory_response, 1'b0);
    check("rst_line", o_memory_line, 32'h0);
    check("rst_req", o_mem_req, 1'b0);
    check("rst_we", o_mem_we, 1'b0);
    check("rst_addr", o_mem_addr, 32'h0);
    check("rst_full", o_wb_full, 1'b0);
    check("rst_ovf", o_wb_overflow, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: plain miss, read from memory after 3 wait cycles
    i_miss      = 1'b1;
    i_miss_addr = 32'h0000_0144;
    do_ack("t1_rd", 1'b0, 32'h0000_0140, 32'h0, 3,
           32'hDEAD_BEEF);
    wait_resp("t1", 32'hDEAD_BEEF, 0);

    // 2: forward from buffer, then drain the entry
    evict(32'h0000_0100, 32'h1111_1111);
    tick();
    i_evict     = 1'b0;
    i_miss      = 1'b1;
    i_miss_addr = 32'h0000_0104;
    check("t2_noreq0", o_mem_req, 1'b0);
    tick();
    check("t2_noreq1", o_mem_req, 1'b0);
    wait_resp("t2", 32'h1111_1111, 0);
    do_ack("t2_wr", 1'b1, 32'h0000_0100, 32'h1111_1111,
           1, 32'h0);
    check("t2_empty", o_wb_full, 1'b0);

    // 3: youngest duplicate wins; both drained in push order
    evict(32'h0000_0300, 32'h3333_0000);
    tick();
    i_evict = 1'b0;
    tick();
    evict(32'h0000_0200, 32'hAAAA_0001);
    tick();
    evict(32'h0000_0200, 32'hBBBB_0002);
    tick();
    i_evict     = 1'b0;
    i_miss      = 1'b1;
    i_miss_addr = 32'h0000_0208;
    do_ack("t3_x", 1'b1, 32'h0000_0300, 32'h3333_0000,
           1, 32'h0);
    wait_resp("t3", 32'hBBBB_0002, 3);
    do_ack("t3_a", 1'b1, 32'h0000_0200, 32'hAAAA_0001,
           0, 32'h0);
    do_ack("t3_b", 1'b1, 32'h0000_0200, 32'hBBBB_0002,
           0, 32'h0);

    // 4: fill to full, drop fifth, overflow sticky until reset
    for (int k = 0; k < 5; k++) begin
      if (k == 3) check("t4_notfull", o_wb_full, 1'b0);
      if (k == 4) check("t4_full", o_wb_full, 1'b1);
      evict(32'h0000_0900 + 32'(k) * 32'h40,
            32'h9000_0000 + 32'(k));
      tick();
    end
    i_evict = 1'b0;
    check("t4_full2", o_wb_full, 1'b1);
    check("t4_ovf", o_wb_overflow, 1'b1);
    repeat (3) tick();
    check("t4_sticky", o_wb_overflow, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_ovf", o_wb_overflow, 1'b0);
    check("t4_rst_full", o_wb_full, 1'b0);
    check("t4_rst_req", o_mem_req, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // 5a: miss and pending drain together -> read first
    evict(32'h0000_0500, 32'h5555_5555);
    tick();
    i_evict     = 1'b0;
    i_miss      = 1'b1;
    i_miss_addr = 32'h0000_0600;
    do_ack("t5_rd", 1'b0, 32'h0000_0600, 32'h0, 0,
           32'h6666_6666);
    wait_resp("t5", 32'h6666_6666, 0);
    do_ack("t5_wr", 1'b1, 32'h0000_0500, 32'h5555_5555,
           0, 32'h0);

    // 5b: full, push and pop in the same cycle
    for (int k = 0; k < 4; k++) begin
      evict(32'h0000_0800 + 32'(k) * 32'h40,
            32'h8000_0000 + 32'(k));
      tick();
    end
    check("t5b_full", o_wb_full, 1'b1);
    check("t5b_head", o_mem_addr, 32'h0000_0800);
    evict(32'h0000_0900, 32'h8000_0004);
    i_mem_ack = 1'b1;
    tick();
    i_evict   = 1'b0;
    i_mem_ack = 1'b0;
    check("t5b_stillfull", o_wb_full, 1'b1);
    check("t5b_noovf", o_wb_overflow, 1'b0);
    do_ack("t5b_e1", 1'b1, 32'h0000_0840, 32'h8000_0001,
           0, 32'h0);
    do_ack("t5b_e2", 1'b1, 32'h0000_0880, 32'h8000_0002,
           0, 32'h0);
    do_ack("t5b_e3", 1'b1, 32'h0000_08C0, 32'h8000_0003,
           0, 32'h0);
    do_ack("t5b_e4", 1'b1, 32'h0000_0900, 32'h8000_0004,
           0, 32'h0);
    check("t5b_drained", o_wb_full, 1'b0);

    // 6: async reset during a read, late ack ignored
    i_miss      = 1'b1;
    i_miss_addr = 32'h0000_0744;
    tick();
    check("t6_req", {o_mem_req, o_mem_addr},
          {1'b1, 32'h0000_0740});
    #2 rst_n = 1'b0;
    #1;
    check("t6_req0", o_mem_req, 1'b0);
    check("t6_addr0", o_mem_addr, 32'h0);
    check("t6_we0", o_mem_we, 1'b0);
    i_miss = 1'b0;
    tick();
    rst_n       = 1'b1;
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h7777_7777;
    tick();
    i_mem_ack   = 1'b0;
    i_mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      check("t6_noresp", o_memory_response, 1'b0);
      check("t6_noreq", o_mem_req, 1'b0);
      tick();
    end
    check("t6_line", o_memory_line, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
